uart_cmd_parser: RTL

Byte-stream command parser between the UART Receiver and the ALU in the serial calculator.
- Consumes received bytes of the form "NNN-NNN-op\n", with 1..3 decimal digits per operand.
- Produces two 8-bit operands and an ALU select code, with a one-cycle valid pulse per well-formed line.
- Detects malformed lines, reports them with an error code, and resynchronises on the next newline.

---
 rtl/calc_pkg.sv | 53 +++++
 rtl/dec_digit_accum.sv | 44 ++++
 rtl/uart_cmd_parser.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the serial calculator: ALU select codes, ASCII
// constants, parser error codes, parser state encoding and small helpers.
package calc_pkg;

   localparam logic [2:0] ADD = 3'd1;
   localparam logic [2:0] SUB = 3'd2;
   localparam logic [2:0] MUL = 3'd3;
   localparam logic [2:0] DIV = 3'd4;

   localparam logic [7:0] CH_NUL  = 8'd0;
   localparam logic [7:0] CH_LF   = 8'd10;
   localparam logic [7:0] CH_CR   = 8'd13;
   localparam logic [7:0] CH_DASH = 8'd45;
   localparam logic [7:0] CH_ZERO = 8'd48;

   localparam logic [2:0] E_NONE    = 3'd0;
   localparam logic [2:0] E_BADCHAR = 3'd1;
   localparam logic [2:0] E_OVF     = 3'd2;
   localparam logic [2:0] E_EMPTY   = 3'd3;
   localparam logic [2:0] E_BADOP   = 3'd4;
   localparam logic [2:0] E_LONG    = 3'd5;

   typedef enum logic [1:0] {
      S_NUM1  = 2'd0,
      S_NUM2  = 2'd1,
      S_OP    = 2'd2,
      S_FLUSH = 2'd3
   } parse_state_t;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CH_ZERO) && (c <= (CH_ZERO + 8'd9));
   endfunction

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= 8'd97) && (c <= 8'd122)) || ((c >= 8'd65) && (c <= 8'd90));
   endfunction

   // Opcode match is case-sensitive; 0 means "not a known opcode".
   function automatic logic [2:0] decode_op(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] c);
      logic [23:0] word;
      word = {a, b, c};
      case (word)
         24'h616464: return ADD;
         24'h737562: return SUB;
         24'h6d756c: return MUL;
         24'h646976: return DIV;
         default:    return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dec_digit_accum.sv
// Decimal digit accumulator shared by both operand fields: value*10+digit,
// with digit counting plus overflow and too-many-digits detection.
module dec_digit_accum
   import calc_pkg::*;
#(
   parameter int DBITS      = 8,
   parameter int MAX_DIGITS = 3,
   parameter int ACC_W      = 10,
   parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             digit_strobe,
   input  logic [3:0]       digit,
   output logic [DBITS-1:0] value,
   output logic [CW-1:0]    count,
   output logic             ovf,
   output logic             too_long
);

   localparam logic [ACC_W+3:0] MAX_VAL = (ACC_W + 4)'((1 << DBITS) - 1);
   localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_DIGITS);

   logic [ACC_W-1:0] acc;
   logic [ACC_W+3:0] next_val;

   // Widened so the candidate value can be compared before it is committed.
   assign next_val = ({4'b0000, acc} * (ACC_W + 4)'(10)) + {{ACC_W{1'b0}}, digit};
   assign ovf      = next_val > MAX_VAL;
   assign too_long = count == CNT_MAX;
   assign value    = acc[DBITS-1:0];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc   <= '0;
         count <= '0;
      end else if (digit_strobe && !ovf && !too_long) begin
         acc   <= next_val[ACC_W-1:0];
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "NNN-NNN-op\n" lines from the UART receiver into ALU operands and
// a select code, flagging malformed lines and resynchronising on newline.
module uart_cmd_parser
   import calc_pkg::*;
#(
   parameter int DBITS      = 8,
   parameter int MAX_DIGITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [DBITS-1:0] rx_data,
   output logic [DBITS-1:0] number1,
   output logic [DBITS-1:0] number2,
   output logic [2:0]       sel,
   output logic             cmd_valid,
   output logic             cmd_error,
   output logic [2:0]       err_code,
   output logic             busy
);

   localparam int CW = $clog2(MAX_DIGITS + 1);

   parse_state_t     state;
   logic [DBITS-1:0] n1_pend;
   logic [DBITS-1:0] n2_pend;
   logic [7:0]       op_buf [3];
   logic [1:0]       op_cnt;

   logic [7:0]       ch;
   logic             in_num;
   logic             acc_clear;
   logic             acc_strobe;
   logic [DBITS-1:0] acc_value;
   logic [CW-1:0]    acc_count;
   logic             acc_ovf;
   logic             acc_long;
   logic [2:0]       op_sel;

   assign ch     = rx_data[7:0];
   assign in_num = (state == S_NUM1) || (state == S_NUM2);
   assign op_sel = decode_op(op_buf[0], op_buf[1], op_buf[2]);
   assign busy   = (state != S_NUM1) || (acc_count != '0);

   // Any significant byte that is not an accepted digit ends the current field.
   always_comb begin
      acc_strobe = 1'b0;
      acc_clear  = 1'b0;
      if (rx_valid && (ch != CH_CR)) begin
         if (in_num && is_digit(ch) && !acc_long && !acc_ovf)
            acc_strobe = 1'b1;
         else
            acc_clear = 1'b1;
      end
   end

   dec_digit_accum #(
      .DBITS      (DBITS),
      .MAX_DIGITS (MAX_DIGITS),
      .ACC_W      (10),
      .CW         (CW)
   ) u_accum (
      .clk          (clk),
      .reset        (reset),
      .clear        (acc_clear),
      .digit_strobe (acc_strobe),
      .digit        (rx_data[3:0]),
      .value        (acc_value),
      .count        (acc_count),
      .ovf          (acc_ovf),
      .too_long     (acc_long)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_NUM1;
         n1_pend   <= '0;
         n2_pend   <= '0;
         op_buf    <= '{default: '0};
         op_cnt    <= '0;
         number1   <= '0;
         number2   <= '0;
         sel       <= '0;
         cmd_valid <= 1'b0;
         cmd_error <= 1'b0;
         err_code  <= E_NONE;
      end else begin
         cmd_valid <= 1'b0;
         cmd_error <= 1'b0;
         if (rx_valid && (ch != CH_CR)) begin
            if (ch == CH_NUL) begin
               state  <= S_NUM1;
               op_cnt <= '0;
            end else begin
               case (state)
                  S_NUM1, S_NUM2: begin
                     if (is_digit(ch)) begin
                        if (acc_long) begin
                           cmd_error <= 1'b1;
                           err_code  <= E_LONG;
                           state     <= S_FLUSH;
                        end else if (acc_ovf) begin
                           cmd_error <= 1'b1;
                           err_code  <= E_OVF;
                           state     <= S_FLUSH;
                        end
                     end else if (ch == CH_DASH) begin
                        if (acc_count == '0) begin
                           cmd_error <= 1'b1;
                           err_code  <= E_EMPTY;
                           state     <= S_FLUSH;
                        end else if (state == S_NUM1) begin
                           n1_pend <= acc_value;
                           state   <= S_NUM2;
                        end else begin
                           n2_pend <= acc_value;
                           op_cnt  <= '0;
                           state   <= S_OP;
                        end
                     end else if (ch == CH_LF) begin
                        // A bare newline at line start is just an empty line.
                        if (!((state == S_NUM1) && (acc_count == '0))) begin
                           cmd_error <= 1'b1;
                           err_code  <= (acc_count == '0) ? E_EMPTY : E_BADCHAR;
                           state     <= S_NUM1;
                        end
                     end else begin
                        cmd_error <= 1'b1;
                        err_code  <= E_BADCHAR;
                        state     <= S_FLUSH;
                     end
                  end
                  S_OP: begin
                     if (is_letter(ch)) begin
                        if (op_cnt == 2'd3) begin
                           cmd_error <= 1'b1;
                           err_code  <= E_BADCHAR;
                           state     <= S_FLUSH;
                        end else begin
                           op_buf[op_cnt] <= ch;
                           op_cnt         <= op_cnt + 2'd1;
                        end
                     end else if (ch == CH_LF) begin
                        if ((op_cnt == 2'd3) && (op_sel != 3'd0)) begin
                           number1   <= n1_pend;
                           number2   <= n2_pend;
                           sel       <= op_sel;
                           cmd_valid <= 1'b1;
                        end else begin
                           cmd_error <= 1'b1;
                           err_code  <= E_BADOP;
                        end
                        op_cnt <= '0;
                        state  <= S_NUM1;
                     end else begin
                        cmd_error <= 1'b1;
                        err_code  <= E_BADCHAR;
                        state     <= S_FLUSH;
                     end
                  end
                  S_FLUSH: begin
                     if (ch == CH_LF)
                        state <= S_NUM1;
                  end
                  default: state <= S_NUM1;
               endcase
            end
         end
      end
   end

endmodule
